vmem_text: RTL and testbench
============================

VMEM_TEXT -- requirements
Module: vmem_text

Interface
REQ-001 SHALL have parameter COLS, default 70, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows on screen.
REQ-003 SHALL have parameter CHAR_W, default 9, glyph cell width in pixels.
REQ-004 SHALL have parameter CHAR_H, default 16, glyph cell height in pixels.
REQ-005 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per cursor blink half-period.
REQ-006 Derived widths: XW = clog2(COLS), YW = clog2(ROWS).
REQ-007 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 key_in  in  8  ASCII code from keyboard.
REQ-010 key_valid  in  1  key_in valid.
REQ-011 key_ready  out  1  block accepts a key this cycle.
REQ-012 clr  in  1  one-cycle pulse, clear screen and home cursor.
REQ-013 x  in  XW  VGA text-cell column being scanned.
REQ-014 y  in  YW  VGA text-cell row being scanned, screen-relative.
REQ-015 h_addr  in  10  VGA pixel column.
REQ-016 v_addr  in  10  VGA pixel row.
REQ-017 ascii_out  out  8  character at screen cell (x,y).
REQ-018 row  out  4  glyph pixel row, v_addr - y*CHAR_H, low 4 bits.
REQ-019 col  out  4  glyph pixel column, h_addr - x*CHAR_W, low 4 bits.
REQ-020 cursor_on  out  1  (x,y) is the cursor cell and blink phase is on.
REQ-021 busy  out  1  block is clearing memory.

Function
REQ-022 Storage: COLS*ROWS bytes, physical address = prow*COLS + col, prow = (top + screen_row) mod ROWS; top is a YW-bit scroll pointer.
REQ-023 State machine: INIT_CLR, IDLE, ROW_CLR; busy = (state != IDLE).
REQ-024 INIT_CLR: write 0 to one address per cycle, addresses 0..COLS*ROWS-1, then IDLE; cursor (cx,cy)=(0,0), top=0.
REQ-025 ROW_CLR: write 0 to COLS cells of the new bottom row, one per cycle, then IDLE.
REQ-026 key_ready = (state == IDLE) && !clr; key accepted on a cycle with key_valid && key_ready.
REQ-027 Accepted printable (0x20..0x7E): write at (cx,cy); if cx < COLS-1, cx+1; else newline per REQ-029.
REQ-028 Accepted 0x08 (backspace): if cx > 0, cx-1 and write 0 at new cell; if cx == 0, no change.
REQ-029 Accepted 0x0A (newline), or wrap: cx=0; if cy < ROWS-1, cy+1, stay IDLE; if cy == ROWS-1, top = (top+1) mod ROWS, cy unchanged, enter ROW_CLR.
REQ-030 Other accepted codes: consumed, no state or memory change.
REQ-031 clr pulse in any state: abort current clear, enter INIT_CLR from address 0; clr beats a simultaneous key_valid.
REQ-032 Read path: ascii_out, row, col, cursor_on registered, latency exactly 1 cycle from x,y,h_addr,v_addr.
REQ-033 Reads are independent of writes; same-cycle write and read of one cell returns the old value.
REQ-034 row/col subtraction in 10 bits, truncated to 4 bits; no range checking.
REQ-035 Blink: counter wraps at BLINK_DIV-1 and toggles the blink phase; cursor_on = phase && x==cx && y==cy, forced 0 while busy.

Reset
REQ-036 Asserting reset: state=INIT_CLR, clear address=0, cx=cy=top=0, blink counter and phase 0, ascii_out/row/col/cursor_on=0; key_ready=0, busy=1.
REQ-037 Release of reset: INIT_CLR runs COLS*ROWS cycles, then IDLE; reset mid-clear restarts the clear at address 0.
REQ-038 Memory array SHALL NOT be reset asynchronously; clearing happens only through INIT_CLR.

Verification
REQ-039 Reset, release, wait 2100 cycles -> busy falls on cycle 2100, key_ready=1, all cells read 0x00.
REQ-040 Send 'A'(0x41), 'B'(0x42) -> x=0,y=0 reads 0x41, x=1,y=0 reads 0x42 one cycle later; cursor at (2,0).
REQ-041 Send 70 x 0x41 -> cursor (0,1); then 0x08 -> cursor unchanged at (0,1); then 0x42, 0x08 -> cell (0,1)=0x00, cursor (0,1).
REQ-042 Send 29 x 0x0A, then 0x5A, 0x0A -> busy high 70 cycles, key_ready low; afterwards y=28 holds 0x5A, y=29 all 0x00, top=1.
REQ-043 clr together with key_valid=1, key_in=0x41 -> key not accepted, busy for 2100 cycles, cursor (0,0), all cells 0.
REQ-044 x=3, y=2, h_addr=30, v_addr=37 -> next cycle col=3, row=5; BLINK_DIV=4 with cursor at (3,2) -> cursor_on toggles every 4 cycles.

Source files
------------

// File: rtl/vmem_text.sv
// Scrolling text-mode video memory: keyboard writes characters at a cursor, VGA scan reads them back.
// The screen scrolls through a ring of physical rows selected by a top-row pointer.
module vmem_text #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int CHAR_W    = 9,
  parameter int CHAR_H    = 16,
  parameter int BLINK_DIV = 25000000,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    key_in,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic          clr,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  output logic [7:0]    ascii_out,
  output logic [3:0]    row,
  output logic [3:0]    col,
  output logic          cursor_on,
  output logic          busy
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BLINK_DIV + 1);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] COLS_A     = AW'(COLS);
  localparam logic [AW-1:0] COLS_M1_A  = AW'(COLS - 1);
  localparam logic [XW-1:0] LAST_COL   = XW'(COLS - 1);
  localparam logic [YW-1:0] LAST_ROW   = YW'(ROWS - 1);
  localparam logic [YW:0]   ROWS_W     = (YW+1)'(ROWS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    IDLE     = 2'd1,
    ROW_CLR  = 2'd2
  } state_t;

  // Screen row r maps to physical row (top + r) mod ROWS.
  function automatic logic [AW-1:0] phys_addr(input logic [YW-1:0] t,
                                               input logic [YW-1:0] r,
                                               input logic [XW-1:0] c);
    logic [YW:0]   s;
    logic [YW-1:0] p;
    s = {1'b0, t} + {1'b0, r};
    if (s >= ROWS_W) p = YW'(s - ROWS_W);
    else             p = s[YW-1:0];
    return AW'(p) * COLS_A + AW'(c);
  endfunction

  state_t        state_q, state_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [YW-1:0] top_q, top_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic [AW-1:0] cend_q, cend_d;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
  logic [7:0]    ascii_q;
  logic [3:0]    row_q, col_q;
  logic          cursor_q;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          do_newline;
  logic [AW-1:0] raddr;
  logic [9:0]    row_full, col_full;
  logic [7:0]    mem [DEPTH];

  assign key_ready = (state_q == IDLE) && !clr;
  assign busy      = (state_q != IDLE);
  assign ascii_out = ascii_q;
  assign row       = row_q;
  assign col       = col_q;
  assign cursor_on = cursor_q;

  // Next-state, cursor and write-port decode for clearing and key handling.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    top_d      = top_q;
    caddr_d    = caddr_q;
    cend_d     = cend_q;
    mem_we     = 1'b0;
    mem_waddr  = caddr_q;
    mem_wdata  = 8'h00;
    do_newline = 1'b0;
    if (clr) begin
      state_d = INIT_CLR;
      caddr_d = {AW{1'b0}};
      cend_d  = LAST_ADDR;
      cx_d    = {XW{1'b0}};
      cy_d    = {YW{1'b0}};
      top_d   = {YW{1'b0}};
    end else begin
      case (state_q)
        INIT_CLR, ROW_CLR: begin
          mem_we = 1'b1;
          if (caddr_q == cend_q) state_d = IDLE;
          else                   caddr_d = caddr_q + {{(AW-1){1'b0}}, 1'b1};
        end
        IDLE: begin
          if (!key_valid) begin
            mem_we = 1'b0;
          end else if (key_in >= 8'h20 && key_in <= 8'h7E) begin
            mem_we    = 1'b1;
            mem_waddr = phys_addr(top_q, cy_q, cx_q);
            mem_wdata = key_in;
            if (cx_q < LAST_COL) cx_d = cx_q + {{(XW-1){1'b0}}, 1'b1};
            else                 do_newline = 1'b1;
          end else if (key_in == 8'h08) begin
            if (cx_q != {XW{1'b0}}) begin
              cx_d      = cx_q - {{(XW-1){1'b0}}, 1'b1};
              mem_we    = 1'b1;
              mem_waddr = phys_addr(top_q, cy_q, cx_q - {{(XW-1){1'b0}}, 1'b1});
            end else begin
              cx_d = cx_q;
            end
          end else if (key_in == 8'h0A) begin
            do_newline = 1'b1;
          end else begin
            do_newline = 1'b0;
          end
        end
        default: begin
          state_d = INIT_CLR;
          caddr_d = {AW{1'b0}};
          cend_d  = LAST_ADDR;
          cx_d    = {XW{1'b0}};
          cy_d    = {YW{1'b0}};
          top_d   = {YW{1'b0}};
        end
      endcase
      // On the last row a newline scrolls: the old top row becomes the new bottom row.
      if (do_newline) begin
        cx_d = {XW{1'b0}};
        if (cy_q < LAST_ROW) begin
          cy_d = cy_q + {{(YW-1){1'b0}}, 1'b1};
        end else begin
          top_d   = (top_q == LAST_ROW) ? {YW{1'b0}} : top_q + {{(YW-1){1'b0}}, 1'b1};
          state_d = ROW_CLR;
          caddr_d = AW'(top_q) * COLS_A;
          cend_d  = AW'(top_q) * COLS_A + COLS_M1_A;
        end
      end else begin
        cy_d = cy_d;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT_CLR;
      cx_q    <= {XW{1'b0}};
      cy_q    <= {YW{1'b0}};
      top_q   <= {YW{1'b0}};
      caddr_q <= {AW{1'b0}};
      cend_q  <= LAST_ADDR;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      top_q   <= top_d;
      caddr_q <= caddr_d;
      cend_q  <= cend_d;
    end
  end

  // Character storage; contents are cleared only by the clear sequences.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Cursor blink timebase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= {BW{1'b0}};
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= {BW{1'b0}};
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
    end
  end

  assign raddr    = phys_addr(top_q, y, x);
  assign row_full = v_addr - 10'(y) * 10'(CHAR_H);
  assign col_full = h_addr - 10'(x) * 10'(CHAR_W);

  // One-cycle registered read path toward the glyph renderer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii_q  <= 8'h00;
      row_q    <= 4'h0;
      col_q    <= 4'h0;
      cursor_q <= 1'b0;
    end else begin
      ascii_q  <= (raddr <= LAST_ADDR) ? mem[raddr] : 8'h00;
      row_q    <= row_full[3:0];
      col_q    <= col_full[3:0];
      cursor_q <= phase_q && (x == cx_q) && (y == cy_q) && (state_q == IDLE);
    end
  end

endmodule

// File: tb/tb_vmem_text.sv
// Directed bench for vmem_text: key/cursor table, scroll, clear and read-path vectors.
module tb_vmem_text;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic       clr;
  logic [6:0] x;
  logic [4:0] y;
  logic [9:0] h_addr, v_addr;
  logic [7:0] ascii_out;
  logic [3:0] row, col;
  logic       cursor_on;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  vmem_text #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .clr(clr), .x(x), .y(y), .h_addr(h_addr),
    .v_addr(v_addr), .ascii_out(ascii_out), .row(row), .col(col),
    .cursor_on(cursor_on), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    int         cell_x, cell_y;
    logic [7:0] cell_exp;
    int         cur_x, cur_y;
  } kvec_t;

  typedef struct {
    int        vx, vy, vh, vv;
    logic [3:0] exp_col, exp_row;
  } pvec_t;

  kvec_t kv[11];
  pvec_t pv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    int w;
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    w = 0;
    while (!key_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) check("key_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic read_cell(input int cx, input int cy, output logic [7:0] v);
    @(negedge clk);
    x = 7'(cx);
    y = 5'(cy);
    @(negedge clk);
    v = ascii_out;
  endtask

  task automatic count_busy(output int n, output int hits);
    n = 0;
    hits = 0;
    while (busy && n < 5000) begin
      if (n > 0 && cursor_on) hits++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic cursor_hits(input int cx, input int cy, output int n);
    @(negedge clk);
    x = 7'(cx);
    y = 5'(cy);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (cursor_on) n++;
    end
  endtask

  task automatic scan_nonzero(input int y0, input int y1, output int n);
    logic [7:0] v;
    n = 0;
    for (int r = y0; r <= y1; r++)
      for (int c = 0; c < 70; c++) begin
        read_cell(c, r, v);
        if (v !== 8'h00) n++;
      end
  endtask

  initial begin
    int n, hits;
    logic [7:0] v;
    logic s[12];

    kv[0]  = '{8'h41, 0, 0, 8'h41, 1, 0};
    kv[1]  = '{8'h42, 1, 0, 8'h42, 2, 0};
    kv[2]  = '{8'h07, 2, 0, 8'h00, 2, 0};
    kv[3]  = '{8'h08, 1, 0, 8'h00, 1, 0};
    kv[4]  = '{8'h43, 1, 0, 8'h43, 2, 0};
    kv[5]  = '{8'h7E, 2, 0, 8'h7E, 3, 0};
    kv[6]  = '{8'h7F, 3, 0, 8'h00, 3, 0};
    kv[7]  = '{8'h1F, 3, 0, 8'h00, 3, 0};
    kv[8]  = '{8'h20, 3, 0, 8'h20, 4, 0};
    kv[9]  = '{8'h0A, 4, 0, 8'h00, 0, 1};
    kv[10] = '{8'h08, 0, 0, 8'h41, 0, 1};

    pv[0] = '{3, 2, 30, 37, 4'd3, 4'd5};
    pv[1] = '{0, 0, 5, 3, 4'd5, 4'd3};
    pv[2] = '{10, 4, 95, 70, 4'd5, 4'd6};
    pv[3] = '{3, 1, 10, 0, 4'hF, 4'h0};
    pv[4] = '{69, 29, 630, 479, 4'd9, 4'hF};

    reset = 1'b1; key_in = 8'h00; key_valid = 1'b0; clr = 1'b0;
    x = 7'd0; y = 5'd0; h_addr = 10'd0; v_addr = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_key_ready", key_ready, 0);
    check("rst_ascii", ascii_out, 0);
    check("rst_row_col", {row, col}, 0);
    check("rst_cursor", cursor_on, 0);

    reset = 1'b0;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midclear_rst_busy", busy, 1);
    reset = 1'b0;
    count_busy(n, hits);
    check("init_clear_cycles", n, 2100);
    check("init_key_ready", key_ready, 1);
    scan_nonzero(0, 29, n);
    check("init_cells_zero", n, 0);

    for (int i = 0; i < 11; i++) begin
      send_key(kv[i].key);
      read_cell(kv[i].cell_x, kv[i].cell_y, v);
      check($sformatf("key%0d_cell", i), v, kv[i].cell_exp);
      cursor_hits(kv[i].cur_x, kv[i].cur_y, n);
      check($sformatf("key%0d_cursor", i), n, 4);
    end

    repeat (70) send_key(8'h41);
    cursor_hits(0, 2, n);
    check("wrap_cursor", n, 4);
    read_cell(69, 1, v);
    check("wrap_last_cell", v, 8'h41);
    send_key(8'h08);
    cursor_hits(0, 2, n);
    check("bs_at_col0_cursor", n, 4);
    send_key(8'h42);
    send_key(8'h08);
    read_cell(0, 2, v);
    check("bs_erase_cell", v, 8'h00);
    cursor_hits(0, 2, n);
    check("bs_erase_cursor", n, 4);

    repeat (27) send_key(8'h0A);
    cursor_hits(0, 29, n);
    check("bottom_cursor", n, 4);
    send_key(8'h5A);
    send_key(8'h0A);
    check("scroll_key_ready", key_ready, 0);
    count_busy(n, hits);
    check("scroll_clear_cycles", n, 70);
    read_cell(0, 28, v);
    check("scroll_z_moved_up", v, 8'h5A);
    read_cell(69, 0, v);
    check("scroll_row1_at_top", v, 8'h41);
    scan_nonzero(29, 29, n);
    check("scroll_bottom_zero", n, 0);
    cursor_hits(0, 29, n);
    check("scroll_cursor", n, 4);

    @(negedge clk);
    x = 7'd0; y = 5'd0;
    clr = 1'b1; key_valid = 1'b1; key_in = 8'h41;
    #1;
    check("clr_blocks_key_ready", key_ready, 0);
    @(negedge clk);
    clr = 1'b0; key_valid = 1'b0;
    count_busy(n, hits);
    check("clr_clear_cycles", n, 2100);
    check("clr_cursor_forced_off", hits, 0);
    cursor_hits(0, 0, n);
    check("clr_cursor_home", n, 4);
    scan_nonzero(0, 29, n);
    check("clr_cells_zero", n, 0);

    send_key(8'h0A);
    send_key(8'h0A);
    send_key(8'h61);
    send_key(8'h62);
    send_key(8'h63);
    @(negedge clk);
    x = 7'd3; y = 5'd2; h_addr = 10'd30; v_addr = 10'd37;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s[i] = cursor_on;
      if (i == 0) begin
        check("pix_col", col, 4'd3);
        check("pix_row", row, 4'd5);
      end
    end
    for (int i = 0; i < 8; i++) check($sformatf("blink_toggle%0d", i), s[i+4], !s[i]);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x = 7'(pv[i].vx); y = 5'(pv[i].vy);
      h_addr = 10'(pv[i].vh); v_addr = 10'(pv[i].vv);
      @(negedge clk);
      check($sformatf("pv%0d_col", i), col, pv[i].exp_col);
      check($sformatf("pv%0d_row", i), row, pv[i].exp_row);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
